// File: rtl/lat_checker.sv
// Latency-aligned result checker: delays golden samples LATENCY cycles,
// compares them against a free-running DUT stream and keeps error status.
module lat_checker #(
  parameter int          WIDTH   = 32,
  parameter int          LATENCY = 4,
  parameter int          CNT_W   = 16,
  parameter int unsigned TOL     = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VIN,
  input  logic [WIDTH-1:0] EXP_IN,
  input  logic             END_IN,
  input  logic [WIDTH-1:0] DUT_OUT,
  output logic             VOUT,
  output logic             ERR_PULSE,
  output logic             ERR,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] FIRST_ERR_IDX,
  output logic [WIDTH-1:0] FIRST_ERR_DATA,
  output logic             DONE
);

  localparam int DW = $clog2(LATENCY + 1);
  localparam logic [WIDTH-1:0] TOL_W = WIDTH'(TOL);
  localparam logic [DW-1:0] LAT_D = DW'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t           state;
  logic [DW-1:0]    dcnt;
  logic [CNT_W-1:0] idx;

  logic [LATENCY-1:0] vld;
  logic [WIDTH-1:0]   exp_q [LATENCY];
  logic [CNT_W-1:0]   idx_q [LATENCY];

  logic             accept;
  logic             take;
  logic             cmp;
  logic             miss;
  logic [WIDTH-1:0] exp_l;
  logic [WIDTH-1:0] diff;

  always_comb begin
    accept = (state == IDLE) || (state == RUN);
    take   = VIN & accept;
    cmp    = vld[LATENCY-1];
    exp_l  = exp_q[LATENCY-1];
    diff   = (DUT_OUT >= exp_l) ? DUT_OUT - exp_l
                                : exp_l - DUT_OUT;
    miss   = cmp && (diff > TOL_W);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      dcnt           <= '0;
      idx            <= '0;
      vld            <= '0;
      VOUT           <= 1'b0;
      ERR_PULSE      <= 1'b0;
      ERR            <= 1'b0;
      CHK_CNT        <= '0;
      ERR_CNT        <= '0;
      FIRST_ERR_IDX  <= '0;
      FIRST_ERR_DATA <= '0;
      DONE           <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        exp_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      // Unconditional shift: the DUT pipeline never stalls
      vld[0]   <= take;
      exp_q[0] <= EXP_IN;
      idx_q[0] <= idx;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i]   <= vld[i-1];
        exp_q[i] <= exp_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
      if (take) idx <= idx + CNT_W'(1);

      VOUT      <= cmp;
      ERR_PULSE <= miss;
      if (cmp && (CHK_CNT != '1))
        CHK_CNT <= CHK_CNT + CNT_W'(1);
      if (miss) begin
        ERR <= 1'b1;
        if (ERR_CNT != '1)
          ERR_CNT <= ERR_CNT + CNT_W'(1);
        if (!ERR) begin
          FIRST_ERR_IDX  <= idx_q[LATENCY-1];
          FIRST_ERR_DATA <= DUT_OUT;
        end
      end

      unique case (state)
        IDLE: begin
          if (END_IN) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else if (take) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (END_IN) begin
            state <= DRAIN;
            dcnt  <= '0;
          end
        end
        DRAIN: begin
          // One extra edge after the last compare before DONE
          if (dcnt == LAT_D) begin
            state <= FIN;
            DONE  <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        FIN: DONE <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lat_checker.sv
// Directed bench for lat_checker: five parameter variants share one
// stimulus stream; each gets a DUT stream delayed by its own latency.
module tb_lat_checker;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VIN;
  logic        END_IN;
  logic [31:0] EXP_IN;

  always #5 CLK = ~CLK;

  logic [31:0] gold  [0:4095];
  logic [31:0] cmask [0:4095];
  int          k;
  logic        offby;
  logic [31:0] d4, d1, d32;

  always_comb begin
    d4  = '0;
    d1  = '0;
    d32 = '0;
    if (offby) begin
      if (k >= 3) d4 = gold[k-3];
    end else if (k >= 4) begin
      d4 = gold[k-4] ^ cmask[k-4];
    end
    if (k >= 1)  d1  = gold[k-1];
    if (k >= 32) d32 = gold[k-32];
  end

  logic [4:0]  vout, errp, err, done;
  logic [15:0] chk  [0:4];
  logic [15:0] ecnt [0:4];
  logic [15:0] fidx [0:4];
  logic [31:0] fdat [0:4];
  logic [3:0]  chk2, ecnt2, fidx2;

  assign chk[2]  = {12'b0, chk2};
  assign ecnt[2] = {12'b0, ecnt2};
  assign fidx[2] = {12'b0, fidx2};

  lat_checker #(.WIDTH(32), .LATENCY(4), .CNT_W(16), .TOL(0)) u0 (
    .CLK(CLK), .RST(RST), .VIN(VIN), .EXP_IN(EXP_IN),
    .END_IN(END_IN), .DUT_OUT(d4),
    .VOUT(vout[0]), .ERR_PULSE(errp[0]), .ERR(err[0]),
    .CHK_CNT(chk[0]), .ERR_CNT(ecnt[0]),
    .FIRST_ERR_IDX(fidx[0]), .FIRST_ERR_DATA(fdat[0]),
    .DONE(done[0])
  );

  lat_checker #(.WIDTH(32), .LATENCY(4), .CNT_W(16), .TOL(1)) u1 (
    .CLK(CLK), .RST(RST), .VIN(VIN), .EXP_IN(EXP_IN),
    .END_IN(END_IN), .DUT_OUT(d4),
    .VOUT(vout[1]), .ERR_PULSE(errp[1]), .ERR(err[1]),
    .CHK_CNT(chk[1]), .ERR_CNT(ecnt[1]),
    .FIRST_ERR_IDX(fidx[1]), .FIRST_ERR_DATA(fdat[1]),
    .DONE(done[1])
  );

  lat_checker #(.WIDTH(32), .LATENCY(4), .CNT_W(4), .TOL(0)) u2 (
    .CLK(CLK), .RST(RST), .VIN(VIN), .EXP_IN(EXP_IN),
    .END_IN(END_IN), .DUT_OUT(d4),
    .VOUT(vout[2]), .ERR_PULSE(errp[2]), .ERR(err[2]),
    .CHK_CNT(chk2), .ERR_CNT(ecnt2),
    .FIRST_ERR_IDX(fidx2), .FIRST_ERR_DATA(fdat[2]),
    .DONE(done[2])
  );

  lat_checker #(.WIDTH(32), .LATENCY(1), .CNT_W(16), .TOL(0)) u3 (
    .CLK(CLK), .RST(RST), .VIN(VIN), .EXP_IN(EXP_IN),
    .END_IN(END_IN), .DUT_OUT(d1),
    .VOUT(vout[3]), .ERR_PULSE(errp[3]), .ERR(err[3]),
    .CHK_CNT(chk[3]), .ERR_CNT(ecnt[3]),
    .FIRST_ERR_IDX(fidx[3]), .FIRST_ERR_DATA(fdat[3]),
    .DONE(done[3])
  );

  lat_checker #(.WIDTH(32), .LATENCY(32), .CNT_W(16), .TOL(0)) u4 (
    .CLK(CLK), .RST(RST), .VIN(VIN), .EXP_IN(EXP_IN),
    .END_IN(END_IN), .DUT_OUT(d32),
    .VOUT(vout[4]), .ERR_PULSE(errp[4]), .ERR(err[4]),
    .CHK_CNT(chk[4]), .ERR_CNT(ecnt[4]),
    .FIRST_ERR_IDX(fidx[4]), .FIRST_ERR_DATA(fdat[4]),
    .DONE(done[4])
  );

  int nchk, nerr;
  int jn;
  int vc [0:4];
  int ec [0:4];
  int vfirst [0:4];
  int efirst [0:4];
  int dfirst [0:4];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gv(input int n);
    if (n == 37) return 32'h3F800000;
    return 32'h40000000 + 32'(n) * 32'h00010203;
  endfunction

  task automatic clr_obs();
    jn = 0;
    for (int i = 0; i < 5; i++) begin
      vc[i] = 0; ec[i] = 0;
      vfirst[i] = -1; efirst[i] = -1; dfirst[i] = -1;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] e,
                      input logic en, input logic [31:0] m);
    VIN = v; EXP_IN = e; END_IN = en;
    gold[k] = e; cmask[k] = m;
    @(posedge CLK);
    #1;
    k++;
    for (int i = 0; i < 5; i++) begin
      if (vout[i]) begin
        vc[i]++;
        if (vfirst[i] < 0) vfirst[i] = jn;
      end
      if (errp[i]) begin
        ec[i]++;
        if (efirst[i] < 0) efirst[i] = jn;
      end
      if (done[i] && dfirst[i] < 0) dfirst[i] = jn;
    end
    jn++;
  endtask

  task automatic rst_run();
    RST = 1'b1;
    step(1'b0, 32'h0, 1'b0, 32'h0);
    RST = 1'b0;
    clr_obs();
  endtask

  initial begin
    nchk = 0; nerr = 0; k = 0; offby = 1'b0;
    RST = 1'b1; VIN = 1'b0; END_IN = 1'b0; EXP_IN = '0;
    for (int i = 0; i < 4096; i++) begin
      gold[i] = '0; cmask[i] = '0;
    end
    clr_obs();
    step(1'b0, 32'h0, 1'b0, 32'h0);
    rst_run();

    check("rst_vout", vout[0], 0);
    check("rst_errp", errp[0], 0);
    check("rst_err", err[0], 0);
    check("rst_chk", chk[0], 0);
    check("rst_ecnt", ecnt[0], 0);
    check("rst_fidx", fidx[0], 0);
    check("rst_fdat", fdat[0], 0);
    check("rst_done", done[0], 0);

    // Exact stream, latency sweep, drain timing
    for (int i = 0; i < 140; i++)
      step(i < 100, i < 100 ? gv(i) : 32'h0, i == 100, 32'h0);
    check("s1_chk_l4", chk[0], 100);
    check("s1_err_l4", err[0], 0);
    check("s1_vc_l4", vc[0], 100);
    check("s1_vfirst_l4", vfirst[0], 4);
    check("s1_done_l4", dfirst[0], 105);
    check("s1_chk_l1", chk[3], 100);
    check("s1_err_l1", ecnt[3], 0);
    check("s1_vfirst_l1", vfirst[3], 1);
    check("s1_done_l1", dfirst[3], 102);
    check("s1_chk_l32", chk[4], 100);
    check("s1_err_l32", ecnt[4], 0);
    check("s1_vfirst_l32", vfirst[4], 32);
    check("s1_done_l32", dfirst[4], 133);

    // Single injected error on sample 37
    rst_run();
    for (int i = 0; i < 108; i++)
      step(i < 100, i < 100 ? gv(i) : 32'h0, 1'b0,
           i == 37 ? 32'h1 : 32'h0);
    check("s2_pulses", ec[0], 1);
    check("s2_pulse_at", efirst[0], 41);
    check("s2_ecnt", ecnt[0], 1);
    check("s2_err", err[0], 1);
    check("s2_fidx", fidx[0], 37);
    check("s2_fdat", fdat[0], 32'h3F800001);
    check("s2_tol1_ecnt", ecnt[1], 0);
    check("s2_tol1_err", err[1], 0);
    check("s2_w4_fidx", fidx[2], 5);
    check("s2_w4_chk", chk[2], 15);

    // Gapped VIN, END with the 10th sample, late VIN/END ignored
    rst_run();
    for (int n = 0; n < 10; n++) begin
      step(1'b1, gv(n), n == 9, 32'h0);
      if (n < 9) step(1'b0, 32'h0, 1'b0, 32'h0);
    end
    step(1'b1, gv(99), 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h0);
    for (int i = 0; i < 40; i++)
      step(1'b0, 32'h0, 1'b0, 32'h0);
    check("s3_chk_l4", chk[0], 10);
    check("s3_err_l4", err[0], 0);
    check("s3_done_l4", dfirst[0], 23);
    check("s3_done_hold", done[0], 1);
    check("s3_chk_l1", chk[3], 10);
    check("s3_done_l1", dfirst[3], 20);
    check("s3_chk_l32", chk[4], 10);
    check("s3_done_l32", dfirst[4], 51);

    // Saturation with 4-bit counters
    rst_run();
    for (int i = 0; i < 28; i++)
      step(i < 20, i < 20 ? gv(i) : 32'h0, 1'b0,
           i < 20 ? 32'h1 : 32'h0);
    check("s4_w4_ecnt", ecnt[2], 15);
    check("s4_w4_chk", chk[2], 15);
    check("s4_w4_fidx", fidx[2], 0);
    check("s4_w4_fdat", fdat[2], 32'h40000001);
    check("s4_w16_ecnt", ecnt[0], 20);
    check("s4_tol1_ecnt", ecnt[1], 0);

    // Reset mid-run with samples in flight
    rst_run();
    for (int i = 0; i < 50; i++)
      step(1'b1, gv(i), 1'b0, 32'h0);
    RST = 1'b1;
    step(1'b1, gv(50), 1'b0, 32'h0);
    RST = 1'b0;
    clr_obs();
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 1'b0, 32'h0);
    check("s5_vout_l4", vc[0], 0);
    check("s5_vout_l32", vc[4], 0);
    check("s5_chk", chk[0], 0);
    check("s5_ecnt", ecnt[0], 0);
    check("s5_done", done[0], 0);
    check("s5_fdat", fdat[0], 0);
    for (int i = 0; i < 28; i++)
      step(i < 20, i < 20 ? gv(i) : 32'h0, 1'b0,
           i == 3 ? 32'h1 : 32'h0);
    check("s5_rerun_chk", chk[0], 20);
    check("s5_rerun_fidx", fidx[0], 3);
    check("s5_rerun_fdat", fdat[0], gv(3) ^ 32'h1);

    // DUT one cycle early: errors equal differing neighbour pairs
    rst_run();
    offby = 1'b1;
    step(1'b1, 32'd5, 1'b0, 32'h0);
    step(1'b1, 32'd5, 1'b0, 32'h0);
    step(1'b1, 32'd7, 1'b0, 32'h0);
    step(1'b1, 32'd7, 1'b0, 32'h0);
    step(1'b1, 32'd7, 1'b0, 32'h0);
    step(1'b1, 32'd9, 1'b0, 32'h0);
    step(1'b1, 32'd9, 1'b0, 32'h0);
    step(1'b1, 32'd9, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 32'd9, 1'b0, 32'h0);
    check("s6_offby_ecnt", ecnt[0], 2);
    check("s6_offby_chk", chk[0], 8);
    offby = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/lat_checker.md
# lat_checker

Parametrised, latency-aligned result checker for pipelined datapath benches such as the FPmul bench. It captures each valid golden value at the input side and holds it in an internal delay line of `LATENCY` stages. When the sample emerges, it compares the value against the DUT output under an optional absolute tolerance. It keeps sticky and pulsed error status, saturating counters, first-failure capture and an end-of-run drain/done state machine, so a bench can check any free-running pipeline of any width and depth without hand-aligning streams.

## Interface
- `WIDTH`, 32: data width of golden and DUT words.
- `LATENCY`, 4: DUT pipeline depth in cycles; legal range 1..32.
- `CNT_W`, 16: width of the sample index and of all counters.
- `TOL`, 0: maximum accepted unsigned |DUT_OUT − expected|; 0 means exact match.
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `VIN` in 1: golden sample valid; `EXP_IN` is sampled when high.
- `EXP_IN` in WIDTH: golden value for the input issued to the DUT this cycle.
- `END_IN` in 1: stimulus finished; starts the drain.
- `DUT_OUT` in WIDTH: DUT result stream, free-running, no stall.
- `VOUT` out 1: a comparison was made at the last edge.
- `ERR_PULSE` out 1: the last comparison mismatched.
- `ERR` out 1: sticky; at least one mismatch since reset.
- `CHK_CNT` out CNT_W: comparisons performed; saturating.
- `ERR_CNT` out CNT_W: mismatches; saturating.
- `FIRST_ERR_IDX` out CNT_W: sample index of the first mismatch.
- `FIRST_ERR_DATA` out WIDTH: `DUT_OUT` value at the first mismatch.
- `DONE` out 1: drain complete; all issued samples checked.

## Operation
- **Reset values:** all outputs are 0, state is IDLE, all delay-line valid bits are 0, and the sample index is 0.
- **Delay line:**
  - `LATENCY` stages, each holding {valid, expected[WIDTH], idx[CNT_W]}.
  - The line shifts every cycle unconditionally.
  - Stage 0 loads {VIN & accept, EXP_IN, sample index}.
  - `accept` is 1 in IDLE and RUN, and 0 in DRAIN and DONE.
- **Sample index:** increments on each accepted VIN and wraps modulo 2^CNT_W.
- **Comparison:**
  - Performed when the last stage is valid.
  - diff = (DUT_OUT ≥ exp) ? DUT_OUT − exp : exp − DUT_OUT, computed in unsigned WIDTH bits.
  - The sample mismatches when diff > TOL.
- **Result registers:** on a comparison, `VOUT` is set to 1 and `CHK_CNT` increments. On a mismatch, `ERR_PULSE`, `ERR` and `ERR_CNT` are updated accordingly.
- **First-failure capture:** `FIRST_ERR_IDX` and `FIRST_ERR_DATA` load only when `ERR` was 0 before that edge.
- **Counters:** both saturate at 2^CNT_W−1 and never wrap.
- **State machine:**
  - IDLE → RUN on the first accepted VIN.
  - IDLE or RUN → DRAIN when END_IN=1. A VIN arriving in the same cycle as END_IN is accepted.
  - DRAIN counts `LATENCY` cycles, then → DONE.
  - DONE: `DONE`=1 and is held; only RST leaves it.
  - END_IN in DRAIN or DONE is ignored. VIN in DRAIN or DONE is dropped and neither counted nor indexed.
- **Reset mid-run:** in any state, all pending samples are discarded, counters and captures are cleared, and the block returns to IDLE.

## Timing
- **Alignment:** `EXP_IN` accepted at edge k is compared with the `DUT_OUT` present at edge k+LATENCY. Results are visible immediately after edge k+LATENCY; the checker adds 0 cycles.
- **Pulse widths:** `VOUT` and `ERR_PULSE` are one-cycle pulses per compared sample. Back-to-back samples give continuous high levels.
- **Done latency:** with END_IN sampled at edge e, DONE rises after edge e+LATENCY+1. The final compare happens at the last drain edge (e+LATENCY), and DONE follows one edge later.
- **Throughput:** one sample per cycle, with no bubbles required.
- **Combinational paths:** none from inputs to outputs.

## Test plan
- **Exact match stream:** WIDTH=32, LATENCY=4, TOL=0; 100 consecutive VIN with DUT_OUT being golden delayed 4 cycles → CHK_CNT=100, ERR=0, VOUT high for 100 cycles starting after edge 4.
- **Single injected error:** corrupt sample 37 (0x3F800000 → 0x3F800001), TOL=0 → ERR_PULSE for exactly one cycle, ERR_CNT=1, FIRST_ERR_IDX=37, FIRST_ERR_DATA=0x3F800001. Rerun with TOL=1 → ERR_CNT=0.
- **Gapped VIN and drain:** VIN on alternate cycles for 10 samples, END_IN on the same cycle as the 10th VIN → CHK_CNT=10, DONE rises after edge e+5. A VIN after END_IN leaves CHK_CNT at 10.
- **Saturation:** CNT_W=4, 20 mismatching samples → ERR_CNT=15, CHK_CNT=15. FIRST_ERR_IDX=0 while the sample index wraps.
- **Reset mid-run:** RST at cycle 50 with 4 samples in flight → no VOUT in the following 4 cycles, all outputs 0, state IDLE. A subsequent run restarts at index 0.
- **Latency sweep:** repeat the first scenario for LATENCY=1 and 32 → zero errors. An off-by-one DUT delay yields ERR_CNT equal to the number of differing neighbour pairs.
